// File: rtl/spi_byte_tx.sv
//----------------------------------------------------------------------------
// spi_byte_tx : SPI mode-0 byte serializer (MSB first) with one-cycle done pulse.
// Optional MISO capture when SPI_RX_CAPTURE_EN is defined.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module spi_byte_tx #(
  parameter int DW      = 8,
  parameter int CLK_DIV = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_send,
  input  logic [DW-1:0] i_data,
  input  logic          i_dc,
  input  logic          i_cs,
  output logic          o_sent,
  output logic          o_busy,
  output logic          o_sck,
  output logic          o_mosi,
  output logic          o_dc,
  output logic          o_cs
`ifdef SPI_RX_CAPTURE_EN
  ,
  input  logic          i_miso,
  output logic [DW-1:0] o_rx_data
`endif
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DW + 1);
  localparam logic [CW-1:0] RELOAD   = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] half_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] shift_reg;
  logic [DW-1:0] shift_next;

  assign shift_next = shift_reg << 1;

`ifdef SPI_RX_CAPTURE_EN
  logic [DW-1:0] rx_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_shift  <= '0;
      o_rx_data <= '0;
    end else begin
      if (state == IDLE && i_send) begin
        rx_shift <= '0;
      end
      // MISO is taken on the last system clock of each high phase.
      if (state == SCK_HI && half_cnt == '0) begin
        rx_shift <= (rx_shift << 1) | DW'(i_miso);
      end
      if (state == SCK_LO && half_cnt == '0 && bit_cnt == LAST_BIT) begin
        o_rx_data <= rx_shift;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      o_sent    <= 1'b0;
      o_busy    <= 1'b0;
      o_sck     <= 1'b0;
      o_mosi    <= 1'b0;
      o_dc      <= 1'b1;
      o_cs      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_send) begin
            // o_dc/o_cs double as the latched copies until DONE.
            shift_reg <= i_data;
            o_mosi    <= i_data[DW-1];
            o_dc      <= i_dc;
            o_cs      <= i_cs;
            o_busy    <= 1'b1;
            half_cnt  <= RELOAD;
            bit_cnt   <= '0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          if (half_cnt != '0) begin
            half_cnt <= half_cnt - CW'(1);
          end else begin
            o_sck    <= 1'b1;
            bit_cnt  <= bit_cnt + BW'(1);
            half_cnt <= RELOAD;
            state    <= SCK_HI;
          end
        end

        SCK_HI: begin
          if (half_cnt != '0) begin
            half_cnt <= half_cnt - CW'(1);
          end else begin
            o_sck     <= 1'b0;
            shift_reg <= shift_next;
            o_mosi    <= shift_next[DW-1];
            half_cnt  <= RELOAD;
            state     <= SCK_LO;
          end
        end

        SCK_LO: begin
          if (half_cnt != '0) begin
            half_cnt <= half_cnt - CW'(1);
          end else if (bit_cnt == LAST_BIT) begin
            o_sent   <= 1'b1;
            half_cnt <= RELOAD;
            state    <= DONE;
          end else begin
            o_sck    <= 1'b1;
            bit_cnt  <= bit_cnt + BW'(1);
            half_cnt <= RELOAD;
            state    <= SCK_HI;
          end
        end

        DONE: begin
          o_sent    <= 1'b0;
          o_busy    <= 1'b0;
          o_mosi    <= 1'b0;
          o_dc      <= 1'b1;
          o_cs      <= 1'b1;
          shift_reg <= '0;
          bit_cnt   <= '0;
          half_cnt  <= '0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_byte_tx.sv
// Testbench for spi_byte_tx: two instances (CLK_DIV=2 and CLK_DIV=1) checked against a cycle-indexed model.
`default_nettype none

module tb_spi_byte_tx;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic       send;
  logic [7:0] data;
  logic       dc;
  logic       cs;

  logic sent2, busy2, sck2, mosi2, dc2, cs2;
  logic sent1, busy1, sck1, mosi1, dc1, cs1;
  logic sent_o, busy_o, sck_o, mosi_o, dc_o, cs_o;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef SPI_RX_CAPTURE_EN
  logic       miso;
  logic [7:0] rx2, rx1, rx_o;
  assign rx_o = sel ? rx1 : rx2;
`endif

  spi_byte_tx #(.DW(8), .CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst_n), .i_send(send & ~sel), .i_data(data), .i_dc(dc), .i_cs(cs),
    .o_sent(sent2), .o_busy(busy2), .o_sck(sck2), .o_mosi(mosi2), .o_dc(dc2), .o_cs(cs2)
`ifdef SPI_RX_CAPTURE_EN
    , .i_miso(miso), .o_rx_data(rx2)
`endif
  );

  spi_byte_tx #(.DW(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst_n), .i_send(send & sel), .i_data(data), .i_dc(dc), .i_cs(cs),
    .o_sent(sent1), .o_busy(busy1), .o_sck(sck1), .o_mosi(mosi1), .o_dc(dc1), .o_cs(cs1)
`ifdef SPI_RX_CAPTURE_EN
    , .i_miso(miso), .o_rx_data(rx1)
`endif
  );

  assign sent_o = sel ? sent1 : sent2;
  assign busy_o = sel ? busy1 : busy2;
  assign sck_o  = sel ? sck1  : sck2;
  assign mosi_o = sel ? mosi1 : mosi2;
  assign dc_o   = sel ? dc1   : dc2;
  assign cs_o   = sel ? cs1   : cs2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sck"},  32'(sck_o),  32'd0);
    chk({tag, "_mosi"}, 32'(mosi_o), 32'd0);
    chk({tag, "_dc"},   32'(dc_o),   32'd1);
    chk({tag, "_cs"},   32'(cs_o),   32'd1);
    chk({tag, "_sent"}, 32'(sent_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  // Called just after a clock edge with the DUT idle; cycle c is the period after edge c,
  // where edge 1 is the one that samples send.
  task automatic xfer(input int div, input logic [7:0] b, input logic dcv, input logic csv,
                      input bit hold, input bit junk, input bit chain, input logic [7:0] nxt,
                      input logic [7:0] m);
    int total, p, sh, nrise, nsent;
    logic [7:0] got;
    logic prev_sck, emosi;
    sel  = (div == 1);
    data = b; dc = dcv; cs = csv; send = 1'b1;
    total = 1 + div * (2 * 8 + 1);
    nrise = 0; nsent = 0; got = '0; prev_sck = 1'b0;
    for (int c = 1; c <= total; c++) begin
      @(posedge clk); #1;
      p  = (c - 1) / div;
      sh = p / 2;
      if (sh < 8) emosi = b[7 - sh]; else emosi = 1'b0;
      chk("sck",  32'(sck_o),  32'(p >= 1 && p <= 16 && (p % 2) == 1));
      chk("mosi", 32'(mosi_o), 32'(emosi));
      chk("busy", 32'(busy_o), 32'd1);
      chk("sent", 32'(sent_o), 32'(c == total));
      chk("dc",   32'(dc_o),   32'(dcv));
      chk("cs",   32'(cs_o),   32'(csv));
      if (sck_o && !prev_sck) begin
        chk("rise_cycle", 32'(c), 32'(1 + div * (1 + 2 * nrise)));
        got = {got[6:0], mosi_o};
        nrise++;
      end
      prev_sck = sck_o;
      if (sent_o) nsent++;
`ifdef SPI_RX_CAPTURE_EN
      if (sh < 8) miso = m[7 - sh]; else miso = 1'b0;
      if (c == total) chk("rx_done", 32'(rx_o), 32'(m));
`endif
      if (c == 1 && !hold) send = 1'b0;
      if (junk) begin
        data = ~b; dc = ~dcv; cs = ~csv;
        send = ((c % 2) == 1);
      end
      if (c == total) begin
        send = chain;
        if (chain) data = nxt;
      end
    end
    @(posedge clk); #1;
    chk_idle("idle_after");
`ifdef SPI_RX_CAPTURE_EN
    chk("rx_hold", 32'(rx_o), 32'(m));
`endif
    chk("byte", 32'(got), 32'(b));
    chk("rises", 32'(nrise), 32'd8);
    chk("sent_count", 32'(nsent), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nsent;
    logic [7:0] rb;
    rst_n = 1'b1; sel = 1'b0; send = 1'b0; data = '0; dc = 1'b0; cs = 1'b0;
`ifdef SPI_RX_CAPTURE_EN
    miso = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk_idle("reset2");
`ifdef SPI_RX_CAPTURE_EN
    chk("rx_reset", 32'(rx_o), 32'd0);
`endif
    sel = 1'b1; #1;
    chk_idle("reset1");
    sel = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("post_reset");

    // Single byte, command, selected.
    xfer(2, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C);
    // Held request: two back-to-back bytes.
    xfer(2, 8'h2C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h96);
    xfer(2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h5A);
    // Inputs churn while busy.
    xfer(2, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hC3);
    // Fastest SCK.
    xfer(1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C);

    // Reset during a transfer.
    sel = 1'b0; data = 8'hE7; dc = 1'b0; cs = 1'b0; send = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) send = 1'b0;
    end
    chk("pre_reset_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("mid_reset");
    @(posedge clk); #1;
    chk_idle("mid_reset_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    nsent = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (sent_o || busy_o) nsent++;
    end
    chk("no_activity_after_reset", 32'(nsent), 32'd0);
    xfer(2, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5);

    // Random bytes on both divider settings.
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      xfer(($urandom_range(0, 1) == 0) ? 1 : 2, rb, 1'($urandom), 1'($urandom),
           1'b0, 1'($urandom), 1'b0, 8'h00, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_byte_tx.md
Name: spi_byte_tx

Overview:
- Serializer at the far end of the ILI9341 command sequencer.
- Accepts one byte per handshake (send / data / dc / cs) and drives it out on SPI mode 0, MSB first.
- Returns a one-cycle done pulse, which the sequencer consumes as its "command sent" input.
- Sits between the command/pixel sequencers and the PYNQ pins: o_sck, o_mosi, o_dc, o_cs.

Parameters:
- DW, 8: bits per transfer.
- CLK_DIV, 2: system clocks per SCK half-period; legal range is ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_send  in  1  transfer request; level-sensitive, sampled only in IDLE.
- i_data  in  DW  byte to transmit.
- i_dc  in  1  data/command level for this byte (0 = command).
- i_cs  in  1  chip-select level for this byte (0 = selected).
- o_sent  out  1  one-cycle pulse when the transfer completes.
- o_busy  out  1  high in every state except IDLE.
- o_sck  out  1  SPI clock; idles low.
- o_mosi  out  1  serial data.
- o_dc  out  1  D/C pin.
- o_cs  out  1  CS pin.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-low.
- Reset / IDLE outputs:
  - o_sent=0, o_busy=0, o_sck=0, o_mosi=0, o_dc=1, o_cs=1.
  - Shift register and counters cleared.
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, DONE.
- IDLE:
  - If i_send=1 on a rising edge: latch i_data, i_dc and i_cs, then go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (CLK_DIV cycles):
  - o_cs and o_dc follow the latched values.
  - o_mosi = latched bit DW-1.
  - o_sck = 0.
- SCK_HI (CLK_DIV cycles):
  - o_sck = 1; o_mosi held.
  - Then go to SCK_LO.
- SCK_LO (CLK_DIV cycles):
  - o_sck = 0.
  - On entry the shift register advances and o_mosi presents the next bit.
  - After the SCK_LO that follows rising edge number DW, go to DONE; otherwise go to SCK_HI.
- DONE (1 cycle):
  - o_sent = 1, o_sck = 0.
  - o_cs and o_dc still hold the latched values.
  - Then go to IDLE.
- Latency: i_send sampled in cycle 0 → o_sent high in cycle 1 + CLK_DIV·(2·DW+1).
  - Example: DW=8, CLK_DIV=2 gives cycle 35.
- Rising SCK edges occur at cycles 1 + CLK_DIV·(1+2k), for k = 0..DW-1.
- The MOSI bit is stable for the full CLK_DIV cycles before and after each rising edge.
- The latched byte, dc and cs are frozen from IDLE exit to DONE.
  - Changes on i_data, i_dc or i_cs while busy have no effect.
  - i_send while busy is ignored; nothing is queued.
- Back-to-back transfers:
  - After DONE the block spends at least one cycle in IDLE, with o_cs=1 and o_dc=1.
  - If i_send is still high in that IDLE cycle, a new transfer starts.
  - The sequencer drops send on the same edge it sees o_sent, so no duplicate transfer occurs.
- Half-period counter:
  - Width is $clog2(CLK_DIV+1).
  - Loaded with CLK_DIV-1 on every state entry; the state exits at 0.
  - CLK_DIV=1 gives 1-cycle phases.
- Bit counter:
  - Width is $clog2(DW+1).
  - Counts rising edges; no wrap beyond DW.
- Reset asserted mid-transfer:
  - Immediate return to IDLE outputs.
  - No o_sent pulse is produced.
  - The latched byte is discarded.

Optional Feature:
- Macro: SPI_RX_CAPTURE_EN.
- Defined:
  - Adds ports i_miso (in, 1) and o_rx_data (out, DW).
  - i_miso is sampled on the last clk cycle of each SCK_HI phase and shifted in MSB first.
  - o_rx_data is updated with the full received word in the DONE cycle and holds until the next DONE.
  - o_rx_data resets to 0.
  - Used for ILI9341 ID/status reads.
- Undefined:
  - Ports and capture logic are absent.
  - TX behaviour and timing are identical.

Test Plan:
- Reset: assert rst=0 mid-run → o_sck=0, o_mosi=0, o_dc=1, o_cs=1, o_sent=0, o_busy=0 immediately.
- Single byte: CLK_DIV=2, i_data=0xA5, i_dc=0, i_cs=0, i_send pulsed in cycle 0.
  - MOSI sampled on SCK rises gives 1,0,1,0,0,1,0,1.
  - Rising edges at cycles 3,7,…,31.
  - o_dc=0 and o_cs=0 during cycles 1–35.
  - o_sent high only in cycle 35.
- Handshake with held request: i_send held high; byte 0x2C then 0x00.
  - Exactly one o_sent per transfer.
  - At least one IDLE cycle with o_cs=1 between transfers.
  - Second transfer's SETUP starts 2 cycles after the first o_sent.
- Busy immunity: after start with 0xFF, toggle i_data to 0x00 and i_send during the transfer → still shifts 0xFF, single o_sent.
- CLK_DIV=1, i_data=0x81: o_sent at cycle 18; SCK period 2 clk.
- Reset mid-transfer: rst=0 in cycle 10, released in cycle 12 → no o_sent; a fresh i_send transfers a clean 0x3C.
- Capture (SPI_RX_CAPTURE_EN defined): i_miso driven 0,0,1,1,1,1,0,0 per bit → o_rx_data=0x3C from the DONE cycle onward.
